// File: rtl/ssd1306_seq_engine.sv
// Microcoded SSD1306 step sequencer: fetches 32-bit steps from a synchronous ROM,
// drives OLED power/reset/DC pins and shifts command/data/stream bytes out over mode-0 SPI.
module ssd1306_seq_engine #(
  parameter int ADDR_W   = 8,
  parameter int CLK_DIV  = 4,
  parameter int TICK_DIV = 50000,
  parameter int DELAY_W  = 24,
  parameter int LOOP_W   = 16
) (
  input  logic              clk_50M,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_data,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              oled_sclk,
  output logic              oled_sdin,
  output logic              ss,
  output logic              oled_dc,
  output logic              oled_res,
  output logic              oled_vdd,
  output logic              oled_vbat
);

  // state    | meaning
  // S_IDLE   | waiting for start after reset
  // S_FETCH  | rom_addr presented, step word arrives next cycle
  // S_EXEC   | decode and execute the step word on rom_data
  // S_DELAY  | counting delay ticks
  // S_SHIFT  | one SPI byte in flight (ss low)
  // S_STREAM | waiting for a host byte on s_data/s_valid
  // S_DONE   | program ended (END or illegal opcode), waiting for start
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_EXEC, S_DELAY, S_SHIFT, S_STREAM, S_DONE
  } state_t;

  localparam logic [3:0] OP_END     = 4'h0;
  localparam logic [3:0] OP_PINS    = 4'h1;
  localparam logic [3:0] OP_DELAY   = 4'h2;
  localparam logic [3:0] OP_CMD     = 4'h3;
  localparam logic [3:0] OP_DATA    = 4'h4;
  localparam logic [3:0] OP_LOOP    = 4'h5;
  localparam logic [3:0] OP_ENDLOOP = 4'h6;
  localparam logic [3:0] OP_STREAM  = 4'h7;

  localparam int DIV_W  = $clog2(CLK_DIV + 1);
  localparam int TICK_W = $clog2(TICK_DIV + 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  state_t              state;
  logic [DELAY_W-1:0]  dly_cnt;
  logic [TICK_W-1:0]   tick_cnt;
  logic [LOOP_W-1:0]   loop_cnt;
  logic [LOOP_W-1:0]   strm_cnt;
  logic [ADDR_W-1:0]   loop_addr;
  logic [DIV_W-1:0]    div_cnt;
  logic [4:0]          half_cnt;
  logic [7:0]          shreg;
  logic                from_stream;

  logic [3:0]  op;
  logic [27:0] arg;
  logic        unused_arg;

  assign op         = rom_data[31:28];
  assign arg        = rom_data[27:0];
  assign unused_arg = ^arg;

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      rom_addr    <= '0;
      s_ready     <= 1'b0;
      oled_sclk   <= 1'b0;
      oled_sdin   <= 1'b0;
      ss          <= 1'b1;
      oled_dc     <= 1'b0;
      oled_res    <= 1'b0;
      oled_vdd    <= 1'b1;
      oled_vbat   <= 1'b1;
      dly_cnt     <= '0;
      tick_cnt    <= '0;
      loop_cnt    <= '0;
      strm_cnt    <= '0;
      loop_addr   <= '0;
      div_cnt     <= '0;
      half_cnt    <= '0;
      shreg       <= '0;
      from_stream <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state    <= S_FETCH;
            rom_addr <= '0;
            done     <= 1'b0;
            error    <= 1'b0;
            busy     <= 1'b1;
          end
        end

        S_FETCH: state <= S_EXEC;

        S_EXEC: begin
          case (op)
            OP_END: begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
            OP_PINS: begin
              oled_vdd  <= arg[2];
              oled_vbat <= arg[1];
              oled_res  <= arg[0];
              rom_addr  <= rom_addr + ADDR_W'(1);
              state     <= S_FETCH;
            end
            OP_DELAY: begin
              rom_addr <= rom_addr + ADDR_W'(1);
              if (arg[DELAY_W-1:0] == '0) begin
                state <= S_FETCH;
              end else begin
                dly_cnt  <= arg[DELAY_W-1:0];
                tick_cnt <= TICK_LAST;
                state    <= S_DELAY;
              end
            end
            OP_CMD, OP_DATA: begin
              rom_addr    <= rom_addr + ADDR_W'(1);
              from_stream <= 1'b0;
              ss          <= 1'b0;
              oled_sclk   <= 1'b0;
              oled_dc     <= (op == OP_DATA);
              oled_sdin   <= arg[7];
              shreg       <= {arg[6:0], 1'b0};
              div_cnt     <= DIV_LAST;
              half_cnt    <= '0;
              state       <= S_SHIFT;
            end
            OP_LOOP: begin
              loop_cnt  <= arg[LOOP_W-1:0];
              loop_addr <= rom_addr + ADDR_W'(1);
              rom_addr  <= rom_addr + ADDR_W'(1);
              state     <= S_FETCH;
            end
            OP_ENDLOOP: begin
              if (loop_cnt != '0) begin
                loop_cnt <= loop_cnt - LOOP_W'(1);
                rom_addr <= loop_addr;
              end else begin
                rom_addr <= rom_addr + ADDR_W'(1);
              end
              state <= S_FETCH;
            end
            OP_STREAM: begin
              rom_addr <= rom_addr + ADDR_W'(1);
              strm_cnt <= arg[LOOP_W-1:0];
              if (arg[LOOP_W-1:0] == '0) begin
                state <= S_FETCH;
              end else begin
                s_ready <= 1'b1;
                state   <= S_STREAM;
              end
            end
            default: begin
              error <= 1'b1;
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_DONE;
            end
          endcase
        end

        S_DELAY: begin
          if (tick_cnt == '0) begin
            tick_cnt <= TICK_LAST;
            if (dly_cnt == DELAY_W'(1)) state <= S_FETCH;
            else                        dly_cnt <= dly_cnt - DELAY_W'(1);
          end else begin
            tick_cnt <= tick_cnt - TICK_W'(1);
          end
        end

        // 16 SCK half-periods plus one trailing half-period keep ss low 17*CLK_DIV cycles
        S_SHIFT: begin
          if (div_cnt != '0) begin
            div_cnt <= div_cnt - DIV_W'(1);
          end else begin
            div_cnt <= DIV_LAST;
            if (half_cnt == 5'd16) begin
              ss <= 1'b1;
              if (from_stream && strm_cnt != '0) begin
                s_ready <= 1'b1;
                state   <= S_STREAM;
              end else begin
                state <= S_FETCH;
              end
            end else begin
              half_cnt  <= half_cnt + 5'd1;
              oled_sclk <= ~oled_sclk;
              if (oled_sclk) begin
                oled_sdin <= shreg[7];
                shreg     <= {shreg[6:0], 1'b0};
              end
            end
          end
        end

        S_STREAM: begin
          if (s_valid && s_ready) begin
            s_ready     <= 1'b0;
            strm_cnt    <= strm_cnt - LOOP_W'(1);
            from_stream <= 1'b1;
            ss          <= 1'b0;
            oled_sclk   <= 1'b0;
            oled_dc     <= 1'b1;
            oled_sdin   <= s_data[7];
            shreg       <= {s_data[6:0], 1'b0};
            div_cnt     <= DIV_LAST;
            half_cnt    <= '0;
            state       <= S_SHIFT;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ssd1306_seq_engine.sv
// Directed bench for ssd1306_seq_engine: a SPI monitor decodes every byte and
// compares it against a queue of expected {dc, byte} values pushed by the stimulus.
module tb_ssd1306_seq_engine;
  localparam int CLK_DIV  = 2;
  localparam int TICK_DIV = 10;

  logic        clk_50M = 1'b0;
  logic        rst_n   = 1'b0;
  logic        start   = 1'b0;
  logic [7:0]  s_data  = 8'h00;
  logic        s_valid = 1'b0;
  logic        busy, done, error, s_ready;
  logic        oled_sclk, oled_sdin, ss, oled_dc, oled_res, oled_vdd, oled_vbat;
  logic [7:0]  rom_addr;
  logic [31:0] rom_data;
  logic [31:0] rom [256];

  int checks = 0;
  int errors = 0;
  int nbytes = 0;
  logic [8:0] exp_q [$];

  ssd1306_seq_engine #(
    .ADDR_W(8), .CLK_DIV(CLK_DIV), .TICK_DIV(TICK_DIV), .DELAY_W(24), .LOOP_W(16)
  ) dut (
    .clk_50M(clk_50M), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .error(error), .rom_addr(rom_addr), .rom_data(rom_data), .s_data(s_data),
    .s_valid(s_valid), .s_ready(s_ready), .oled_sclk(oled_sclk), .oled_sdin(oled_sdin),
    .ss(ss), .oled_dc(oled_dc), .oled_res(oled_res), .oled_vdd(oled_vdd),
    .oled_vbat(oled_vbat)
  );

  always #10 clk_50M = ~clk_50M;
  always @(posedge clk_50M) rom_data <= rom[rom_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // SPI monitor: MOSI sampled on SCK rising, byte closed on ss rising
  logic       prev_ss = 1'b1;
  logic       prev_sclk = 1'b0;
  int         low_cnt = 0;
  int         rises = 0;
  logic [7:0] sh = 8'h00;

  always @(negedge clk_50M) begin
    if (!rst_n) begin
      prev_ss = 1'b1; prev_sclk = 1'b0; low_cnt = 0; rises = 0;
    end else begin
      if (!ss) begin
        low_cnt++;
        check("rdy_in_shift", s_ready, 0);
        if (oled_sclk && !prev_sclk) begin
          sh = {sh[6:0], oled_sdin};
          rises++;
        end
      end
      if (ss && !prev_ss) begin
        check("sck_rises", rises, 8);
        check("ss_low_len", low_cnt, 17 * CLK_DIV);
        if (exp_q.size() == 0) check("spurious_byte", exp_q.size(), 1);
        else check("spi_byte", {oled_dc, sh}, exp_q.pop_front());
        nbytes++;
        low_cnt = 0;
        rises = 0;
      end
      prev_ss = ss;
      prev_sclk = oled_sclk;
    end
  end

  task automatic load(input logic [31:0] w0, input logic [31:0] w1,
                      input logic [31:0] w2, input logic [31:0] w3);
    for (int i = 0; i < 256; i++) rom[i] = 32'h0;
    rom[0] = w0; rom[1] = w1; rom[2] = w2; rom[3] = w3;
  endtask

  task automatic pulse_start();
    @(negedge clk_50M) start = 1'b1;
    @(negedge clk_50M) start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 5000) begin
      @(negedge clk_50M);
      n++;
    end
    check({tag, "_done_timeout"}, n < 5000, 1);
  endtask

  // Cycles from the start negedge until ss is seen low; a second start is
  // pulsed mid-run and must be ignored while busy.
  task automatic time_to_ss(input logic [31:0] w0, output int n);
    load(w0, 32'h4000_005A, 32'h0, 32'h0);
    exp_q.push_back(9'h15A);
    @(negedge clk_50M) start = 1'b1;
    n = 0;
    while (ss && n < 1000) begin
      @(negedge clk_50M);
      n++;
      if (n == 1)  start = 1'b0;
      if (n == 10) start = 1'b1;
      if (n == 11) start = 1'b0;
    end
    start = 1'b0;
    wait_done("delay");
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    exp_q.push_back({1'b1, b});
    @(negedge clk_50M);
    while (!s_ready && n < 500) begin
      @(negedge clk_50M);
      n++;
    end
    check("s_ready_wait", n < 500, 1);
    s_data = b;
    s_valid = 1'b1;
    @(negedge clk_50M) s_valid = 1'b0;
    check("s_ready_drop", s_ready, 0);
  endtask

  initial begin
    #(20 * 60000);
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb, n0, n3;
    load(32'h0, 32'h0, 32'h0, 32'h0);
    repeat (3) @(negedge clk_50M);
    check("reset_outs", {busy, done, error, s_ready, oled_sclk, oled_sdin, ss, oled_dc,
                         oled_res, oled_vdd, oled_vbat}, 11'b000000_1_0_0_1_1);
    check("reset_addr", rom_addr, 0);
    #3 rst_n = 1'b1;

    // PINS 0b011 then END: pins change on the EXEC edge, done two cycles later
    nb = nbytes;
    load(32'h1000_0003, 32'h0, 32'h0, 32'h0);
    pulse_start();
    check("pins_busy", busy, 1);
    @(negedge clk_50M);
    check("pins_before", {oled_vdd, oled_vbat, oled_res}, 3'b110);
    @(negedge clk_50M);
    check("pins_after", {oled_vdd, oled_vbat, oled_res}, 3'b011);
    repeat (2) @(negedge clk_50M);
    check("pins_done", {busy, done, error}, 3'b010);
    check("pins_no_spi", nbytes - nb, 0);

    // CMD 0xAF
    nb = nbytes;
    exp_q.push_back(9'h0AF);
    load(32'h3000_00AF, 32'h0, 32'h0, 32'h0);
    pulse_start();
    wait_done("cmd");
    check("cmd_count", nbytes - nb, 1);
    check("cmd_q_empty", exp_q.size(), 0);

    // DELAY 0 vs DELAY 3 before DATA 0x5A: 2 FETCH/EXEC pairs + 30 delay cycles
    time_to_ss(32'h2000_0000, n0);
    time_to_ss(32'h2000_0003, n3);
    check("dly0_latency", n0, 5);
    check("dly3_latency", n3, 35);
    check("dly_q_empty", exp_q.size(), 0);

    // LOOP 2 / CMD 0x00 / ENDLOOP: body runs three times
    nb = nbytes;
    repeat (3) exp_q.push_back(9'h000);
    load(32'h5000_0002, 32'h3000_0000, 32'h6000_0000, 32'h0);
    pulse_start();
    wait_done("loop");
    check("loop_count", nbytes - nb, 3);
    check("loop_cnt_end", dut.loop_cnt, 0);
    check("loop_q_empty", exp_q.size(), 0);

    // STREAM 4 with a host stall before the third byte
    nb = nbytes;
    load(32'h7000_0004, 32'h0, 32'h0, 32'h0);
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h02);
    n0 = 0;
    while (!s_ready && n0 < 500) begin
      @(negedge clk_50M);
      n0++;
    end
    repeat (5) begin
      @(negedge clk_50M);
      check("stall_ss_high", {ss, s_ready}, 2'b11);
    end
    send_byte(8'h03);
    send_byte(8'h04);
    wait_done("stream");
    check("stream_count", nbytes - nb, 4);
    check("stream_q_empty", exp_q.size(), 0);
    check("stream_dc", oled_dc, 1);

    // Reset in the middle of CMD 0xAF, then a clean rerun from address 0
    exp_q.push_back(9'h0AF);
    load(32'h3000_00AF, 32'h0, 32'h0, 32'h0);
    pulse_start();
    n0 = 0;
    while (ss && n0 < 100) begin
      @(negedge clk_50M);
      n0++;
    end
    repeat (10) @(negedge clk_50M);
    #3 rst_n = 1'b0;
    #1 check("rst_async", {ss, oled_sclk, oled_vdd, busy}, 4'b1010);
    exp_q.delete();
    @(negedge clk_50M);
    #3 rst_n = 1'b1;
    nb = nbytes;
    exp_q.push_back(9'h0AF);
    pulse_start();
    check("rerun_addr", rom_addr, 0);
    wait_done("rerun");
    check("rerun_count", nbytes - nb, 1);
    check("rerun_q_empty", exp_q.size(), 0);

    // Illegal opcode: error and done, pins untouched; start clears both
    load(32'h9000_0000, 32'h0, 32'h0, 32'h0);
    pulse_start();
    wait_done("illegal");
    check("illegal_flags", {busy, done, error}, 3'b011);
    check("illegal_pins", {oled_vdd, oled_vbat, oled_res}, 3'b110);
    pulse_start();
    check("illegal_clear", {busy, done, error}, 3'b100);
    wait_done("illegal2");
    check("illegal_again", error, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ssd1306_seq_engine.md
Name: ssd1306_seq_engine

Overview:
- Parametrised successor to the fixed-timing SSD1306 init block: a microcoded OLED step sequencer with an integrated mode-0 SPI byte shifter.
- It fetches 32-bit step words from an external synchronous ROM and drives the OLED power, reset and DC pins.
- It sends command and data bytes, supports tick-based relative delays and a hardware loop.
- It streams host pixel bytes through a valid/ready port.
- It sits between the board clock/reset and the Pmod OLED pins; a host FSM starts sequences (init, clear, frame push).

Parameters:
- ADDR_W, 8: ROM address width; the program counter wraps modulo 2^ADDR_W.
- CLK_DIV, 4: clk_50M cycles per SCK half-period; legal range >=1.
- TICK_DIV, 50000: clk_50M cycles per delay tick (1 ms at 50 MHz); legal range >=1.
- DELAY_W, 24: width of the delay argument, in ticks.
- LOOP_W, 16: width of the loop and stream counters.

Ports:
- clk_50M, in, 1: the single clock.
- rst_n, in, 1: reset, asynchronous, active-low.
- start, in, 1: begin program at address 0. Sampled only when busy=0.
- busy, out, 1: high from the cycle after start until END or error.
- done, out, 1: level, set on END or error, cleared by start.
- error, out, 1: level, set on illegal opcode, cleared by start.
- rom_addr, out, ADDR_W: step address.
- rom_data, in, 32: step word, valid 1 cycle after rom_addr.
- s_data, in, 8: stream byte.
- s_valid, in, 1: stream byte valid.
- s_ready, out, 1: engine accepts s_data. A transfer occurs when s_valid&&s_ready.
- oled_sclk, out, 1: SPI clock, mode 0.
- oled_sdin, out, 1: SPI MOSI, MSB first.
- ss, out, 1: SPI select, active-low.
- oled_dc, out, 1: 0 = command, 1 = data.
- oled_res, out, 1: panel reset, active-low.
- oled_vdd, out, 1: logic supply enable, active-low.
- oled_vbat, out, 1: panel supply enable, active-low.

Behaviour:
- Reset values: busy=0, done=0, error=0, rom_addr=0, s_ready=0, oled_sclk=0, oled_sdin=0, ss=1, oled_dc=0, oled_res=0, oled_vdd=1, oled_vbat=1.
  - All internal counters are cleared.
  - Reset mid-operation aborts any byte immediately (ss=1 asynchronously); no partial-byte completion.
- Step word: op=[31:28], arg=[27:0].
  - 0x0 END: go to DONE, set done.
  - 0x1 PINS: vdd=arg[2], vbat=arg[1], res=arg[0], all in the same cycle.
  - 0x2 DELAY: wait arg[DELAY_W-1:0] ticks. The tick prescaler restarts on entry, so N ticks take exactly N*TICK_DIV cycles. N=0 adds no wait.
  - 0x3 CMD: send arg[7:0] with dc=0.
  - 0x4 DATA: send arg[7:0] with dc=1.
  - 0x5 LOOP: loop_cnt=arg[LOOP_W-1:0], loop_addr=current address+1. A LOOP inside an active loop overwrites both; there is no nesting.
  - 0x6 ENDLOOP: if loop_cnt!=0, decrement and jump to loop_addr; else fall through. The body therefore runs loop_cnt+1 times.
  - 0x7 STREAM: transfer arg[LOOP_W-1:0] host bytes with dc=1. A count of 0 falls through.
  - 0x8-0xF: set error and done, go to DONE. Pins hold their values.
- FSM states: IDLE, FETCH, EXEC, DELAY, SHIFT, STREAM, DONE.
  - IDLE/DONE -> FETCH on start. rom_addr=0, done=0, error=0, busy=1.
  - FETCH waits 1 cycle, then goes to EXEC.
  - EXEC decodes, then goes to FETCH at the next address, to DELAY, SHIFT or STREAM, or to DONE.
  - start is ignored while busy.
- Non-wait steps (PINS, LOOP, ENDLOOP) cost 2 cycles each: FETCH+EXEC.
- SHIFT sequence:
  - Cycle 0: ss=0, dc valid, sdin=bit7.
  - Every CLK_DIV cycles SCK toggles; sdin changes only on SCK falling edges.
  - After the 8th falling edge, ss=1.
  - ss is low for exactly 17*CLK_DIV cycles. ss stays high for at least 1 cycle before the next byte.
  - dc holds until the next byte starts.
- STREAM:
  - s_ready=1 only when SHIFT is idle and bytes remain.
  - On a transfer, s_ready drops the next cycle, the byte is shifted, and the counter decrements.
  - s_valid low stalls indefinitely with ss=1.
  - After the last byte, go to FETCH.
- The address increments modulo 2^ADDR_W; wrap from max to 0 is legal and not flagged.
- busy falls, and done rises, in the same cycle DONE is entered.

Test Plan (CLK_DIV=2, TICK_DIV=10 unless noted):
- Reset then ROM {PINS 0b011, END}, pulse start -> vdd=0, vbat=1, res=1 on EXEC of step 0. done=1, busy=0 on step 1; ss never low.
- ROM {CMD 0xAF, END} -> ss low 34 cycles, sclk 8 rising edges, sampled MOSI 1,0,1,0,1,1,1,1, dc=0.
- ROM {DELAY 3, DATA 0x5A, END} -> ss falls exactly 30 cycles after DELAY EXEC. dc=1, MOSI 0x5A.
- ROM {LOOP 2, CMD 0x00, ENDLOOP, END} -> exactly 3 CMD bytes 0x00, then done; loop_cnt=0 at END.
- ROM {STREAM 4, END}, host bytes 0x01,0x02,0x03,0x04 with s_valid low for 5 cycles before the 3rd -> 4 bytes in order. s_ready=0 during each shift; ss high during the stall.
- Reset mid-byte (rst_n low at cycle 10 of CMD 0xAF) -> ss=1, sclk=0, vdd=1 immediately. After release and start, the sequence restarts at address 0. Separately, ROM {0x9...} -> error=1, done=1.
